glb_cfg_tile_responder: RTL and testbench
=========================================

# glb_cfg_tile_responder

Receiving end of the CGRA parallel-configuration bus, placed at each CGRA tile column where the global buffer drives configuration packets. Each cycle it decodes one `{addr, data, wr_en, rd_en}` packet, writes a local configuration register file when the tile ID matches, and returns read data onto an OR-combined response chain. It also forwards every packet, registered, to the next tile in the column and flags protocol errors.

## Interface
Parameters:
- `CFG_ADDR_WIDTH`, 32: configuration address width.
- `CFG_DATA_WIDTH`, 32: configuration data and register width.
- `TILE_ID_WIDTH`, 16: tile-ID field, `addr[TILE_ID_WIDTH-1:0]`.
- `REG_ADDR_WIDTH`, 8: register-index field, `addr[TILE_ID_WIDTH +: REG_ADDR_WIDTH]`.
- `NUM_REGS`, 16: implemented registers, `NUM_REGS <= 2**REG_ADDR_WIDTH`.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: reset, asynchronous and active-low.
- `tile_id` in TILE_ID_WIDTH: this tile's ID, quasi-static.
- `cfg_in_addr` in CFG_ADDR_WIDTH: incoming packet address.
- `cfg_in_data` in CFG_DATA_WIDTH: incoming write data.
- `cfg_in_wr_en` in 1: write strobe.
- `cfg_in_rd_en` in 1: read strobe.
- `cfg_out_addr`, `cfg_out_data`, `cfg_out_wr_en`, `cfg_out_rd_en` out (same widths): registered copy of the packet, sent to the next tile.
- `rd_data_in` in CFG_DATA_WIDTH: response from the downstream tile.
- `rd_data_out` out CFG_DATA_WIDTH: local response OR `rd_data_in`.
- `cfg_regs` out NUM_REGS*CFG_DATA_WIDTH: flattened register file; register k occupies `[k*CFG_DATA_WIDTH +: CFG_DATA_WIDTH]`.
- `err_sticky` out 1: sticky protocol-error flag.
- `err_clr` in 1: clears `err_sticky`.

## Operation
- Hit: `cfg_in_addr[TILE_ID_WIDTH-1:0] == tile_id`. Index `idx = cfg_in_addr[TILE_ID_WIDTH +: REG_ADDR_WIDTH]`.
- Valid write: hit, `wr_en=1`, `rd_en=0`, `idx < NUM_REGS`. Register `idx` takes `cfg_in_data` at the next edge.
- Valid read: hit, `rd_en=1`, `wr_en=0`, `idx < NUM_REGS`. The local read-data register captures register `idx`. In every other cycle that register captures 0.
- `rd_data_out = rd_q | rd_data_in`, combinational. The local contribution is nonzero only for the single cycle after a valid read.
- Error event occurs on either of:
  - `wr_en & rd_en` both high, regardless of hit;
  - a hit with a strobe set and `idx >= NUM_REGS`.
- On an error event: no write, read data 0, `err_sticky` is set at the next edge.
- `err_clr` clears the flag at the next edge. If an error event and `err_clr` occur in the same cycle, set wins.
- Pass-through: every packet, including hits, misses and errors, is forwarded unchanged. The tile does not consume packets.
- Upper address bits above `TILE_ID_WIDTH+REG_ADDR_WIDTH` are ignored.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` deassert is the caller's responsibility) drives these to 0:
  - all `cfg_regs`
  - local read register
  - `err_sticky`
  - `cfg_out_addr`, `cfg_out_data`, `cfg_out_wr_en`, `cfg_out_rd_en`
- While in reset, `rd_data_out` therefore equals `rd_data_in`.
- Packet at edge N:
  - a write is visible on `cfg_regs` after edge N+1;
  - read data appears on `rd_data_out` during cycle N+1 only;
  - the forwarded packet appears on `cfg_out_*` during cycle N+1.
- Back-to-back write then read of the same register: the read returns the new value.
- Reads issued on consecutive cycles give consecutive one-cycle responses with no bubble.
- No backpressure: one packet per cycle is always accepted.
- Reset asserted mid-stream: all state clears immediately. A pending read response is dropped, with no partial output.

## Test plan
- Reset, then write 0xDEADBEEF to (tile 5, reg 3) with `tile_id=5` -> after 1 cycle reg 3 = 0xDEADBEEF, other regs 0; `cfg_out_*` repeats the packet 1 cycle later.
- Write 0x1234 then read (tile 5, reg 3) on the next cycle -> `rd_data_out` = 0x1234 for exactly one cycle, then 0.
- Read with `tile_id` mismatch (addr tile 6) and `rd_data_in=0xA0` -> `rd_data_out` stays 0xA0; regs unchanged; packet forwarded.
- Write to reg 20 (>= NUM_REGS=16) on a hit, then a separate cycle with both strobes high -> no register change; `err_sticky=1` after the first; `err_clr` with a concurrent error keeps it 1; a lone `err_clr` clears it.
- Read reg 3 (value 0x0F) while `rd_data_in=0xF0` -> `rd_data_out` = 0xFF for one cycle.
- Assert `reset` between a read's issue cycle and its response cycle -> no response; all outputs 0 immediately; regs 0.

Source files
------------

// File: rtl/glb_cfg_tile_responder.sv
// Per-column configuration responder: decodes packets addressed to this tile,
// maintains a local register file, ORs read data onto the chain and forwards packets.
module glb_cfg_tile_responder #(
    parameter int CFG_ADDR_WIDTH = 32,
    parameter int CFG_DATA_WIDTH = 32,
    parameter int TILE_ID_WIDTH  = 16,
    parameter int REG_ADDR_WIDTH = 8,
    parameter int NUM_REGS       = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [TILE_ID_WIDTH-1:0]            tile_id,
    input  logic [CFG_ADDR_WIDTH-1:0]           cfg_in_addr,
    input  logic [CFG_DATA_WIDTH-1:0]           cfg_in_data,
    input  logic                                cfg_in_wr_en,
    input  logic                                cfg_in_rd_en,
    output logic [CFG_ADDR_WIDTH-1:0]           cfg_out_addr,
    output logic [CFG_DATA_WIDTH-1:0]           cfg_out_data,
    output logic                                cfg_out_wr_en,
    output logic                                cfg_out_rd_en,
    input  logic [CFG_DATA_WIDTH-1:0]           rd_data_in,
    output logic [CFG_DATA_WIDTH-1:0]           rd_data_out,
    output logic [NUM_REGS*CFG_DATA_WIDTH-1:0]  cfg_regs,
    output logic                                err_sticky,
    input  logic                                err_clr
);

    logic [REG_ADDR_WIDTH-1:0] idx;
    logic                      hit;
    logic                      idx_ok;
    logic                      both_strobes;
    logic                      err_event;
    logic                      wr_ok;
    logic                      rd_ok;
    logic [CFG_DATA_WIDTH-1:0] rd_sel;
    logic [CFG_DATA_WIDTH-1:0] rd_q;

    assign hit          = (cfg_in_addr[TILE_ID_WIDTH-1:0] == tile_id);
    assign idx          = cfg_in_addr[TILE_ID_WIDTH +: REG_ADDR_WIDTH];
    // Extra bit so NUM_REGS == 2**REG_ADDR_WIDTH compares correctly.
    assign idx_ok       = ({1'b0, idx} < (REG_ADDR_WIDTH+1)'(NUM_REGS));
    assign both_strobes = cfg_in_wr_en & cfg_in_rd_en;
    assign err_event    = both_strobes | (hit & (cfg_in_wr_en | cfg_in_rd_en) & ~idx_ok);
    assign wr_ok        = hit & cfg_in_wr_en & ~cfg_in_rd_en & idx_ok;
    assign rd_ok        = hit & cfg_in_rd_en & ~cfg_in_wr_en & idx_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
            logic [CFG_DATA_WIDTH-1:0] q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q <= '0;
                end else if (wr_ok && (idx == REG_ADDR_WIDTH'(gi))) begin
                    q <= cfg_in_data;
                end
            end
            assign cfg_regs[gi*CFG_DATA_WIDTH +: CFG_DATA_WIDTH] = q;
        end
    endgenerate

    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (idx == REG_ADDR_WIDTH'(k)) begin
                rd_sel = cfg_regs[k*CFG_DATA_WIDTH +: CFG_DATA_WIDTH];
            end
        end
    end

    // rd_q returns to zero every cycle that is not a valid read so it can be OR-chained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_ok ? rd_sel : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_sticky <= 1'b0;
        end else if (err_event) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_out_addr  <= '0;
            cfg_out_data  <= '0;
            cfg_out_wr_en <= 1'b0;
            cfg_out_rd_en <= 1'b0;
        end else begin
            cfg_out_addr  <= cfg_in_addr;
            cfg_out_data  <= cfg_in_data;
            cfg_out_wr_en <= cfg_in_wr_en;
            cfg_out_rd_en <= cfg_in_rd_en;
        end
    end

    assign rd_data_out = rd_q | rd_data_in;

endmodule

// File: tb/tb_glb_cfg_tile_responder.sv
// Scoreboard bench for glb_cfg_tile_responder: the driver queues hand-computed
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_glb_cfg_tile_responder;

    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [15:0]   tile_id = 16'd5;
    logic [31:0]   cfg_in_addr = '0;
    logic [31:0]   cfg_in_data = '0;
    logic          cfg_in_wr_en = 1'b0;
    logic          cfg_in_rd_en = 1'b0;
    logic [31:0]   cfg_out_addr;
    logic [31:0]   cfg_out_data;
    logic          cfg_out_wr_en;
    logic          cfg_out_rd_en;
    logic [31:0]   rd_data_in = '0;
    logic [31:0]   rd_data_out;
    logic [NR*32-1:0] cfg_regs;
    logic          err_sticky;
    logic          err_clr = 1'b0;

    glb_cfg_tile_responder dut (
        .clk(clk), .reset(reset), .tile_id(tile_id),
        .cfg_in_addr(cfg_in_addr), .cfg_in_data(cfg_in_data),
        .cfg_in_wr_en(cfg_in_wr_en), .cfg_in_rd_en(cfg_in_rd_en),
        .cfg_out_addr(cfg_out_addr), .cfg_out_data(cfg_out_data),
        .cfg_out_wr_en(cfg_out_wr_en), .cfg_out_rd_en(cfg_out_rd_en),
        .rd_data_in(rd_data_in), .rd_data_out(rd_data_out),
        .cfg_regs(cfg_regs), .err_sticky(err_sticky), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic        rdn;
        logic        err;
        int          i1;
        logic [31:0] v1;
        int          i2;
        logic [31:0] v2;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int txn = 0;

    function automatic logic [31:0] a(input logic [15:0] t, input logic [7:0] r);
        return {8'h00, r, t};
    endfunction

    function automatic logic [31:0] reg_at(input int i);
        return cfg_regs[i*32 +: 32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic send(input logic [31:0] addr, input logic [31:0] data,
                        input logic wr, input logic rd, input logic [31:0] rdin,
                        input logic clr, input logic push,
                        input logic [31:0] e_rd, input logic e_err,
                        input int i1, input logic [31:0] v1,
                        input int i2, input logic [31:0] v2);
        exp_t e;
        @(negedge clk);
        #1;
        cfg_in_addr  = addr;
        cfg_in_data  = data;
        cfg_in_wr_en = wr;
        cfg_in_rd_en = rd;
        rd_data_in   = rdin;
        err_clr      = clr;
        if (push) begin
            e.rd = e_rd; e.addr = addr; e.data = data; e.wr = wr; e.rdn = rd;
            e.err = e_err; e.i1 = i1; e.v1 = v1; e.i2 = i2; e.v2 = v2;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: one line per observed transaction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d: addr=0x%08h wr=%0b rd=%0b rd_data_out=0x%08h err=%0b",
                         txn, cfg_out_addr, cfg_out_wr_en, cfg_out_rd_en, rd_data_out, err_sticky);
                chk("rd_data_out", rd_data_out, e.rd);
                chk("cfg_out_addr", cfg_out_addr, e.addr);
                chk("cfg_out_data", cfg_out_data, e.data);
                chk("cfg_out_wr_en", {31'd0, cfg_out_wr_en}, {31'd0, e.wr});
                chk("cfg_out_rd_en", {31'd0, cfg_out_rd_en}, {31'd0, e.rdn});
                chk("err_sticky", {31'd0, err_sticky}, {31'd0, e.err});
                chk($sformatf("reg%0d", e.i1), reg_at(e.i1), e.v1);
                chk($sformatf("reg%0d", e.i2), reg_at(e.i2), e.v2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_data_in = 32'h55;
        #2;
        chk("reset rd_data_out", rd_data_out, 32'h55);
        chk("reset cfg_out_addr", cfg_out_addr, 32'h0);
        chk("reset err", {31'd0, err_sticky}, 32'h0);
        for (int i = 0; i < NR; i++) chk($sformatf("reset reg%0d", i), reg_at(i), 32'h0);
        repeat (3) @(negedge clk);
        rd_data_in = '0;
        reset = 1'b1;

        //    addr              data          wr rd rdin     clr push e_rd          err i1 v1             i2 v2
        send(a(5,3),          32'hDEADBEEF, 1, 0, 32'h0,  0, 1, 32'h0,        0,  3, 32'hDEADBEEF,  4, 32'h0);
        send(a(5,3),          32'h1234,     1, 0, 32'h0,  0, 1, 32'h0,        0,  3, 32'h1234,      0, 32'h0);
        send(a(5,3),          32'h0,        0, 1, 32'h0,  0, 1, 32'h1234,     0,  3, 32'h1234,      0, 32'h0);
        send(32'h0,           32'h0,        0, 0, 32'h0,  0, 1, 32'h0,        0,  3, 32'h1234,      0, 32'h0);
        send(a(6,3),          32'h0,        0, 1, 32'hA0, 0, 1, 32'hA0,       0,  3, 32'h1234,      0, 32'h0);
        send(a(6,3),          32'h55,       1, 0, 32'hA0, 0, 1, 32'hA0,       0,  3, 32'h1234,      0, 32'h0);
        send(a(5,20),         32'h777,      1, 0, 32'h0,  0, 1, 32'h0,        1,  3, 32'h1234,      4, 32'h0);
        send(a(5,2),          32'h99,       1, 1, 32'h0,  1, 1, 32'h0,        1,  2, 32'h0,         3, 32'h1234);
        send(32'h0,           32'h0,        0, 0, 32'h0,  1, 1, 32'h0,        0,  2, 32'h0,         3, 32'h1234);
        send(a(7,1),          32'h0,        1, 1, 32'h0,  0, 1, 32'h0,        1,  1, 32'h0,         3, 32'h1234);
        send(a(5,16),         32'h0,        0, 1, 32'h0,  1, 1, 32'h0,        1,  0, 32'h0,         3, 32'h1234);
        send(32'h0,           32'h0,        0, 0, 32'h0,  1, 1, 32'h0,        0,  0, 32'h0,         3, 32'h1234);
        send(a(5,3),          32'h0F,       1, 0, 32'h0,  0, 1, 32'h0,        0,  3, 32'h0F,        0, 32'h0);
        send(a(5,3),          32'h0,        0, 1, 32'hF0, 0, 1, 32'hFF,       0,  3, 32'h0F,        0, 32'h0);
        send(32'h0,           32'h0,        0, 0, 32'hF0, 0, 1, 32'hF0,       0,  3, 32'h0F,        0, 32'h0);
        send(32'hAB010005,    32'hCAFE,     1, 0, 32'h0,  0, 1, 32'h0,        0,  1, 32'hCAFE,      3, 32'h0F);
        send(a(5,15),         32'h5A5A,     1, 0, 32'h0,  0, 1, 32'h0,        0, 15, 32'h5A5A,      1, 32'hCAFE);
        send(a(5,1),          32'h0,        0, 1, 32'h0,  0, 1, 32'hCAFE,     0,  1, 32'hCAFE,     15, 32'h5A5A);
        send(32'hFF0F0005,    32'h0,        0, 1, 32'h0,  0, 1, 32'h5A5A,     0,  1, 32'hCAFE,     15, 32'h5A5A);
        send(32'h0,           32'h0,        0, 0, 32'h0,  0, 1, 32'h0,        0,  1, 32'hCAFE,     15, 32'h5A5A);
        send(a(5,1),          32'h0,        1, 1, 32'h0,  0, 1, 32'h0,        1,  1, 32'hCAFE,     15, 32'h5A5A);
        // Read of reg 3 whose response is cut off by reset: no expectation queued.
        send(a(5,3),          32'h0,        0, 1, 32'h0,  0, 0, 32'h0,        0,  0, 32'h0,         0, 32'h0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst rd_data_out", rd_data_out, 32'h0);
        chk("midrst cfg_out_addr", cfg_out_addr, 32'h0);
        chk("midrst cfg_out_rd_en", {31'd0, cfg_out_rd_en}, 32'h0);
        chk("midrst err", {31'd0, err_sticky}, 32'h0);
        for (int i = 0; i < NR; i++) chk($sformatf("midrst reg%0d", i), reg_at(i), 32'h0);
        @(negedge clk);
        chk("midrst resp cycle", rd_data_out, 32'h0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
